// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, result strobe WIDTH+1 cycles after accept.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_flush,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             r_state;
   logic [2:0]         r_op;
   logic [2*WIDTH:0]   r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_neg;
   logic               r_dz;
   logic [CW-1:0]      r_count;
   logic               r_valid;
   logic [WIDTH-1:0]   r_result;

   logic               w_a_signed, w_b_signed, w_neg_a, w_neg_b, w_neg_res;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH:0]   w_mul_next, w_shift, w_div_next;
   logic [WIDTH+1:0]   w_trial;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0]   w_quot, w_rem, w_final;

   assign w_a_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
   assign w_b_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
   assign w_neg_a    = w_a_signed & i_a[WIDTH-1];
   assign w_neg_b    = w_b_signed & i_b[WIDTH-1];
   assign w_mag_a    = w_neg_a ? -i_a : i_a;
   assign w_mag_b    = w_neg_b ? -i_b : i_b;
   // Remainder takes the dividend's sign; products and quotients the xor of both.
   assign w_neg_res  = (i_op[2] && i_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

   // Multiply: high half accumulates the multiplicand, whole register shifts right.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
   assign w_mul_next = r_acc[0] ? {1'b0, w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH:1]};

   // Divide: partial remainder in the high half, quotient bits shift in at the bottom.
   assign w_shift    = {r_acc[2*WIDTH-1:0], 1'b0};
   assign w_trial    = {1'b0, w_shift[2*WIDTH:WIDTH]} - {2'b00, r_opnd};
   assign w_div_next = w_trial[WIDTH+1] ? w_shift
                                        : {w_trial[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};

   assign w_prod     = r_acc[2*WIDTH-1:0];
   assign w_prod_fix = r_neg ? -w_prod : w_prod;
   assign w_quot     = r_acc[WIDTH-1:0];
   assign w_rem      = r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_final = w_prod[WIDTH-1:0];
      case (r_op)
         3'd1, 3'd2, 3'd3: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:       w_final = r_dz ? '1 : (r_neg ? -w_quot : w_quot);
         3'd6, 3'd7:       w_final = r_neg ? -w_rem : w_rem;
         default:          w_final = w_prod[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_neg    <= 1'b0;
         r_dz     <= 1'b0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else begin
         r_valid <= 1'b0;
         if (i_flush) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_valid) begin
                     r_op    <= i_op;
                     r_opnd  <= i_op[2] ? w_mag_b : w_mag_a;
                     r_acc   <= {{(WIDTH+1){1'b0}}, (i_op[2] ? w_mag_a : w_mag_b)};
                     r_neg   <= w_neg_res;
                     r_dz    <= (i_b == '0);
                     r_count <= '0;
                     r_state <= BUSY;
                  end
               end
               BUSY: begin
                  r_acc   <= r_op[2] ? w_div_next : w_mul_next;
                  r_count <= r_count + 1'b1;
                  if (r_count == CW'(WIDTH - 1)) r_state <= DONE;
               end
               DONE: begin
                  r_result <= w_final;
                  r_valid  <= 1'b1;
                  r_state  <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_ready  = (r_state == IDLE);
   assign o_valid  = r_valid;
   assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Runs 8/32/64-bit builds side by side; every result, its latency and its pulse
// count are compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, valid, other_en;
   logic [2:0]  op;
   logic [7:0]  a8, b8, r8;
   logic [31:0] a32, b32, r32;
   logic [63:0] a64, b64, r64;
   logic        rdy8, rdy32, rdy64, v8, v32, v64;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int          q_c8[$], q_c32[$], q_c64[$];
   logic [63:0] q_r8[$], q_r32[$], q_r64[$];

   muldiv_unit #(.WIDTH(8)) u8 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid & other_en), .i_op(op), .i_a(a8), .i_b(b8),
      .i_flush(flush), .o_ready(rdy8), .o_valid(v8), .o_result(r8));
   muldiv_unit #(.WIDTH(32)) u32 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op(op), .i_a(a32), .i_b(b32),
      .i_flush(flush), .o_ready(rdy32), .o_valid(v32), .o_result(r32));
   muldiv_unit #(.WIDTH(64)) u64 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid & other_en), .i_op(op), .i_a(a64), .i_b(b64),
      .i_flush(flush), .o_ready(rdy64), .o_valid(v64), .o_result(r64));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (v8)  begin q_r8.push_back(64'(r8));   q_c8.push_back(cyc);  end
      if (v32) begin q_r32.push_back(64'(r32)); q_c32.push_back(cyc); end
      if (v64) begin q_r64.push_back(r64);      q_c64.push_back(cyc); end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Truncating signed/unsigned arithmetic on wide integers, with the
   // divide-by-zero and overflow results defined for the unit.
   function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0]         m;
      logic signed [129:0] ua, ub, sa, sb, r, mn;
      m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      ua = {66'd0, a & m};
      ub = {66'd0, b & m};
      sa = ua;
      sb = ub;
      if (a[w-1]) sa = ua - (130'sd1 <<< w);
      if (b[w-1]) sb = ub - (130'sd1 <<< w);
      mn = -(130'sd1 <<< (w - 1));
      case (o)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: r = (ua * ub) >>> w;
         3'd4: begin
            if (ub == 0) r = '1;
            else if (sa == mn && sb == -1) r = sa;
            else r = sa / sb;
         end
         3'd5: begin
            if (ub == 0) r = '1;
            else r = ua / ub;
         end
         3'd6: begin
            if (ub == 0) r = sa;
            else if (sa == mn && sb == -1) r = 0;
            else r = sa % sb;
         end
         default: begin
            if (ub == 0) r = ua;
            else r = ua % ub;
         end
      endcase
      return r[63:0] & m;
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] m;
      m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      case ($urandom_range(0, 9))
         0:       return 64'd0;
         1:       return 64'd1;
         2:       return m;
         3:       return 64'd1 << (w - 1);
         4:       return m >> 1;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   task automatic scramble();
      op  = 3'($urandom);
      a8  = 8'($urandom);  b8  = 8'($urandom);
      a32 = $urandom;      b32 = $urandom;
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
   endtask

   task automatic check_out(input string tag, input int w, input int n, input int c,
                            input logic [63:0] r, input int acc, input logic [63:0] e);
      check($sformatf("%s w%0d pulses", tag, w), 64'(n), 64'd1);
      check($sformatf("%s w%0d latency", tag, w), 64'(c - acc), 64'(w + 1));
      check($sformatf("%s w%0d result", tag, w), r, e);
   endtask

   task automatic run_txn(input string tag, input logic [2:0] o,
                          input logic [63:0] x8, input logic [63:0] y8,
                          input logic [63:0] x32, input logic [63:0] y32,
                          input logic [63:0] x64, input logic [63:0] y64,
                          input logic [63:0] spec32, input bit use_spec, output int acc);
      logic [63:0] e8, e32, e64, got32;
      q_r8.delete();  q_c8.delete();
      q_r32.delete(); q_c32.delete();
      q_r64.delete(); q_c64.delete();
      if (clk) @(negedge clk);
      op = o; other_en = 1'b1; valid = 1'b1;
      a8 = x8[7:0]; b8 = y8[7:0]; a32 = x32[31:0]; b32 = y32[31:0]; a64 = x64; b64 = y64;
      @(posedge clk); #1;
      acc = cyc;
      valid = 1'b0;
      scramble();
      check({tag, " busy"}, 64'(rdy32), 64'd0);
      repeat (70) @(posedge clk);
      @(negedge clk);
      e8  = model(8, o, x8, y8);
      e32 = model(32, o, x32, y32);
      e64 = model(64, o, x64, y64);
      got32 = (q_r32.size() > 0) ? q_r32[0] : 64'hDEAD;
      check_out(tag, 8,  q_r8.size(),  (q_c8.size()  > 0) ? q_c8[0]  : -1000,
                (q_r8.size()  > 0) ? q_r8[0]  : 64'hDEAD, acc, e8);
      check_out(tag, 32, q_r32.size(), (q_c32.size() > 0) ? q_c32[0] : -1000, got32, acc, e32);
      check_out(tag, 64, q_r64.size(), (q_c64.size() > 0) ? q_c64[0] : -1000,
                (q_r64.size() > 0) ? q_r64[0] : 64'hDEAD, acc, e64);
      if (use_spec) check({tag, " w32 value"}, got32, spec32);
      $display("TXN %-12s op=%0d a=%h b=%h res=%h exp=%h", tag, o, x32[31:0], y32[31:0],
               got32[31:0], e32[31:0]);
   endtask

   int          acc;
   int          bb_acc[3];
   logic [2:0]  bb_op[3];
   logic [63:0] bb_a[3], bb_b[3];
   int          budget;
   logic [2:0]  rop;

   initial begin
      rst = 1'b1; flush = 1'b0; valid = 1'b0; other_en = 1'b1;
      op = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0; a64 = '0; b64 = '0;
      #1;
      check("reset ready", 64'({rdy8, rdy32, rdy64}), 64'h7);
      check("reset valid", 64'({v8, v32, v64}), 64'h0);
      check("reset result32", 64'(r32), 64'h0);
      check("reset result64", r64, 64'h0);
      #1 rst = 1'b0;

      run_txn("MUL", 3'd0, pick(8), pick(8), 64'd7, 64'hFFFFFFFD, pick(64), pick(64),
              64'hFFFFFFEB, 1'b1, acc);
      check("first accept cycle", 64'(acc), 64'd1);
      run_txn("MULHU", 3'd3, pick(8), pick(8), 64'hFFFFFFFF, 64'hFFFFFFFF, pick(64), pick(64),
              64'hFFFFFFFE, 1'b1, acc);
      run_txn("MULHSU", 3'd2, pick(8), pick(8), 64'hFFFFFFFF, 64'd2, pick(64), pick(64),
              64'hFFFFFFFF, 1'b1, acc);
      run_txn("DIV", 3'd4, pick(8), pick(8), 64'hFFFFFFF9, 64'd2, pick(64), pick(64),
              64'hFFFFFFFD, 1'b1, acc);
      run_txn("REM", 3'd6, pick(8), pick(8), 64'hFFFFFFF9, 64'd2, pick(64), pick(64),
              64'hFFFFFFFF, 1'b1, acc);
      run_txn("DIVU", 3'd5, pick(8), pick(8), 64'h80000000, 64'd2, pick(64), pick(64),
              64'h40000000, 1'b1, acc);
      run_txn("DIV by0", 3'd4, 64'h85, 64'd0, 64'h12345678, 64'd0, 64'h8000000000000001, 64'd0,
              64'hFFFFFFFF, 1'b1, acc);
      run_txn("DIVU by0", 3'd5, 64'h85, 64'd0, 64'hDEADBEEF, 64'd0, 64'd9, 64'd0,
              64'hFFFFFFFF, 1'b1, acc);
      run_txn("REM by0", 3'd6, 64'h85, 64'd0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFF0, 64'd0,
              64'd5, 1'b1, acc);
      run_txn("REMU by0", 3'd7, 64'h85, 64'd0, 64'd5, 64'd0, 64'd77, 64'd0,
              64'd5, 1'b1, acc);
      run_txn("DIV ovf", 3'd4, 64'h80, 64'hFF, 64'h80000000, 64'hFFFFFFFF,
              64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h80000000, 1'b1, acc);
      run_txn("REM ovf", 3'd6, 64'h80, 64'hFF, 64'h80000000, 64'hFFFFFFFF,
              64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, acc);

      // Flush at BUSY cycle 10: the 8-bit build has already finished by then.
      q_r8.delete(); q_r32.delete(); q_r64.delete();
      q_c8.delete(); q_c32.delete(); q_c64.delete();
      @(negedge clk);
      op = 3'd1; a8 = 8'h93; b8 = 8'h27; a32 = 32'h12345678; b32 = 32'h9ABCDEF0;
      a64 = 64'h0123456789ABCDEF; b64 = 64'hFEDCBA9876543210; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      check("flush busy ready32", 64'(rdy32), 64'd1);
      check("flush busy ready64", 64'(rdy64), 64'd1);
      check("flush busy valid32", 64'(v32), 64'd0);
      flush = 1'b0;
      repeat (70) @(posedge clk);
      check("flush busy pulses32", 64'(q_r32.size()), 64'd0);
      check("flush busy pulses64", 64'(q_r64.size()), 64'd0);
      check("flush busy pulses8", 64'(q_r8.size()), 64'd1);
      $display("TXN %-12s flush at busy cycle 10", "FLUSH BUSY");

      // Flush together with a request in IDLE: nothing is accepted.
      q_r8.delete(); q_r32.delete(); q_r64.delete();
      @(negedge clk); valid = 1'b1; flush = 1'b1; op = 3'd0;
      @(posedge clk); #1;
      check("flush idle ready", 64'({rdy8, rdy32, rdy64}), 64'h7);
      valid = 1'b0; flush = 1'b0;
      repeat (70) @(posedge clk);
      check("flush idle pulses", 64'(q_r8.size() + q_r32.size() + q_r64.size()), 64'd0);
      $display("TXN %-12s flush with request in idle", "FLUSH IDLE");

      // Asynchronous reset between edges while busy.
      @(negedge clk);
      op = 3'd5; a32 = 32'hFFFF0000; b32 = 32'd3; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async rst ready32", 64'(rdy32), 64'd1);
      check("async rst valid32", 64'(v32), 64'd0);
      check("async rst result32", 64'(r32), 64'd0);
      @(negedge clk); rst = 1'b0;
      q_r8.delete(); q_r32.delete(); q_r64.delete();
      repeat (70) @(posedge clk);
      check("async rst pulses", 64'(q_r8.size() + q_r32.size() + q_r64.size()), 64'd0);
      $display("TXN %-12s reset mid-busy", "ASYNC RST");

      // Back-to-back requests on the 32-bit build with i_valid held high.
      other_en = 1'b0;
      q_r32.delete(); q_c32.delete(); q_r8.delete(); q_r64.delete();
      for (int k = 0; k < 3; k++) begin
         bb_op[k] = 3'($urandom);
         bb_a[k]  = pick(32);
         bb_b[k]  = pick(32);
      end
      @(negedge clk);
      op = bb_op[0]; a32 = bb_a[0][31:0]; b32 = bb_b[0][31:0]; valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         budget = 0;
         while (!rdy32 && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         check($sformatf("b2b ready wait %0d", k), 64'(budget < 100), 64'd1);
         @(posedge clk); #1;
         bb_acc[k] = cyc;
         if (k < 2) begin
            op = bb_op[k+1]; a32 = bb_a[k+1][31:0]; b32 = bb_b[k+1][31:0];
         end else begin
            valid = 1'b0;
         end
      end
      repeat (70) @(posedge clk);
      @(negedge clk);
      check("b2b pulses32", 64'(q_r32.size()), 64'd3);
      check("b2b others idle", 64'(q_r8.size() + q_r64.size()), 64'd0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) check($sformatf("b2b spacing %0d", k), 64'(bb_acc[k] - bb_acc[k-1]), 64'd34);
         check($sformatf("b2b latency %0d", k),
               64'(((q_c32.size() > k) ? q_c32[k] : -1000) - bb_acc[k]), 64'd33);
         check($sformatf("b2b result %0d", k), (q_r32.size() > k) ? q_r32[k] : 64'hDEAD,
               model(32, bb_op[k], bb_a[k], bb_b[k]));
         $display("TXN %-12s op=%0d a=%h b=%h exp=%h", $sformatf("B2B %0d", k), bb_op[k],
                  bb_a[k][31:0], bb_b[k][31:0], model(32, bb_op[k], bb_a[k], bb_b[k]));
      end
      other_en = 1'b1;

      for (int t = 0; t < 40; t++) begin
         rop = 3'($urandom);
         run_txn($sformatf("RAND %0d", t), rop, pick(8), pick(8), pick(32), pick(32),
                 pick(64), pick(64), 64'd0, 1'b0, acc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
